// File: rtl/isle_text_pkg.sv
// Shared text-console definitions: cell layout, control codes, geometry and FSM states.
package isle_text_pkg;

  // Default console geometry
  localparam int unsigned DefHres  = 84;
  localparam int unsigned DefVres  = 24;
  localparam int unsigned DefDepth = DefHres * DefVres;  // 2016

  // Cell layout: [31:28] fg, [27:24] bg, [23:21] zero, [20:0] code point
  localparam int unsigned CellFgLsb = 28;
  localparam int unsigned CellBgLsb = 24;
  localparam int unsigned CellCodeW = 21;

  // Control codes and the blank glyph
  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChBs    = 8'h08;
  localparam logic [7:0] ChBlank = 8'h20;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StNewline,
    StClrline
  } state_e;

endpackage

// File: rtl/textcon.sv
// Text console writer: turns a byte stream into tram cell writes, tracks the
// cursor, handles LF/CR/BS and scrolls by advancing scroll_offs.
module textcon
  import isle_text_pkg::*;
#(
  parameter int unsigned ADDRW     = 11,
  parameter int unsigned WORD      = 32,
  parameter int unsigned BYTE_CNT  = 4,
  parameter int unsigned CIDXW     = 4,
  parameter int unsigned TEXT_HRES = DefHres,
  parameter int unsigned TEXT_VRES = DefVres,
  localparam int unsigned ColW     = $clog2(TEXT_HRES),
  localparam int unsigned RowW     = $clog2(TEXT_VRES)
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic                ch_valid,
  output logic                ch_ready,
  input  logic [7:0]          ch_data,
  input  logic [CIDXW-1:0]    fg_colr,
  input  logic [CIDXW-1:0]    bg_colr,
  input  logic                clear,
  output logic                busy,
  output logic [BYTE_CNT-1:0] tram_we,
  output logic [ADDRW-1:0]    tram_addr,
  output logic [WORD-1:0]     tram_din,
  output logic [ADDRW-1:0]    scroll_offs,
  output logic [ColW-1:0]     cur_col,
  output logic [RowW-1:0]     cur_row
);

  localparam int unsigned Depth = TEXT_HRES * TEXT_VRES;

  localparam logic [ADDRW-1:0] HresA    = ADDRW'(TEXT_HRES);
  localparam logic [ADDRW-1:0] LastCell = ADDRW'(Depth - 1);
  localparam logic [ADDRW-1:0] LastCol  = ADDRW'(TEXT_HRES - 1);
  localparam logic [ColW-1:0]  LastColC = ColW'(TEXT_HRES - 1);
  localparam logic [RowW-1:0]  LastRow  = RowW'(TEXT_VRES - 1);

  // Single compare-and-subtract wrap; operands are always below Depth.
  function automatic logic [ADDRW-1:0] add_wrap(input logic [ADDRW-1:0] a,
                                                input logic [ADDRW-1:0] b);
    logic [ADDRW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (ADDRW+1)'(Depth)) s = s - (ADDRW+1)'(Depth);
    return s[ADDRW-1:0];
  endfunction

  function automatic logic [WORD-1:0] make_cell(input logic [CIDXW-1:0] fg,
                                                input logic [CIDXW-1:0] bg,
                                                input logic [7:0]       code);
    logic [WORD-1:0] c;
    c = '0;
    c[CellFgLsb +: CIDXW] = fg;
    c[CellBgLsb +: CIDXW] = bg;
    c[7:0]                = code;
    return c;
  endfunction

  state_e              r_state, w_state_d;
  logic [ADDRW-1:0]    r_cnt, w_cnt_d;
  logic [ColW-1:0]     r_col, w_col_d;
  logic [RowW-1:0]     r_row, w_row_d;
  logic [ADDRW-1:0]    r_line_base, w_line_base_d;
  logic [ADDRW-1:0]    r_scroll, w_scroll_d;
  logic [BYTE_CNT-1:0] r_we, w_we_d;
  logic [ADDRW-1:0]    r_addr, w_addr_d;
  logic [WORD-1:0]     r_din, w_din_d;

  logic            w_ready;
  logic            w_accept;
  logic [WORD-1:0] w_blank;

  assign w_ready  = !rst_sys && (r_state == StIdle) && !clear;
  assign w_accept = w_ready && ch_valid;
  assign w_blank  = make_cell(fg_colr, bg_colr, ChBlank);

  // State register; reset aborts any clear/scroll and restarts with a full clear.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state     <= StClear;
      r_cnt       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_line_base <= '0;
      r_scroll    <= '0;
      r_we        <= '0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_col       <= w_col_d;
      r_row       <= w_row_d;
      r_line_base <= w_line_base_d;
      r_scroll    <= w_scroll_d;
      r_we        <= w_we_d;
      r_addr      <= w_addr_d;
      r_din       <= w_din_d;
    end
  end

  // Next-state, cursor and tram write-port decode.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_col_d       = r_col;
    w_row_d       = r_row;
    w_line_base_d = r_line_base;
    w_scroll_d    = r_scroll;
    w_we_d        = '0;
    w_addr_d      = r_addr;
    w_din_d       = r_din;

    case (r_state)
      StClear: begin
        w_we_d   = '1;
        w_addr_d = r_cnt;
        w_din_d  = w_blank;
        w_cnt_d  = r_cnt + 1'b1;
        if (r_cnt == LastCell) begin
          w_cnt_d       = '0;
          w_scroll_d    = '0;
          w_col_d       = '0;
          w_row_d       = '0;
          w_line_base_d = '0;
          w_state_d     = StIdle;
        end
      end

      StIdle: begin
        if (!rst_sys && clear) begin
          w_cnt_d   = '0;
          w_state_d = StClear;
        end else if (w_accept) begin
          if (ch_data == ChLf) begin
            w_col_d   = '0;
            w_state_d = StNewline;
          end else if (ch_data == ChCr) begin
            w_col_d = '0;
          end else if (ch_data == ChBs) begin
            if (r_col != '0) w_col_d = r_col - 1'b1;
          end else begin
            w_we_d   = '1;
            w_addr_d = add_wrap(r_line_base, ADDRW'(r_col));
            w_din_d  = make_cell(fg_colr, bg_colr, ch_data);
            if (r_col == LastColC) begin
              w_col_d   = '0;
              w_state_d = StNewline;
            end else begin
              w_col_d = r_col + 1'b1;
            end
          end
        end
      end

      StNewline: begin
        w_line_base_d = add_wrap(r_line_base, HresA);
        if (r_row != LastRow) begin
          w_row_d   = r_row + 1'b1;
          w_state_d = StIdle;
        end else begin
          w_scroll_d = add_wrap(r_scroll, HresA);
          w_cnt_d    = '0;
          w_state_d  = StClrline;
        end
      end

      StClrline: begin
        // line_base already points at the line that just scrolled into view
        w_we_d   = '1;
        w_addr_d = add_wrap(r_line_base, r_cnt);
        w_din_d  = w_blank;
        w_cnt_d  = r_cnt + 1'b1;
        if (r_cnt == LastCol) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end
      end

      default: w_state_d = StClear;
    endcase
  end

  assign ch_ready    = w_ready;
  assign busy        = !rst_sys && (r_state != StIdle);
  assign tram_we     = r_we;
  assign tram_addr   = r_addr;
  assign tram_din    = r_din;
  assign scroll_offs = r_scroll;
  assign cur_col     = r_col;
  assign cur_row     = r_row;

endmodule

// File: tb/tb_textcon.sv
// Directed self-checking bench for textcon.
module tb_textcon;

  logic        clk_sys;
  logic        rst_sys;
  logic        ch_valid;
  logic        ch_ready;
  logic [7:0]  ch_data;
  logic [3:0]  fg_colr;
  logic [3:0]  bg_colr;
  logic        clear;
  logic        busy;
  logic [3:0]  tram_we;
  logic [10:0] tram_addr;
  logic [31:0] tram_din;
  logic [10:0] scroll_offs;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  int checks;
  int failures;

  textcon dut (
    .clk_sys     (clk_sys),
    .rst_sys     (rst_sys),
    .ch_valid    (ch_valid),
    .ch_ready    (ch_ready),
    .ch_data     (ch_data),
    .fg_colr     (fg_colr),
    .bg_colr     (bg_colr),
    .clear       (clear),
    .busy        (busy),
    .tram_we     (tram_we),
    .tram_addr   (tram_addr),
    .tram_din    (tram_din),
    .scroll_offs (scroll_offs),
    .cur_col     (cur_col),
    .cur_row     (cur_row)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until accepted; returns cycles spent waiting.
  task automatic send(input logic [7:0] b, output int stall);
    ch_data  = b;
    ch_valid = 1'b1;
    stall    = 0;
    #1;
    while (!ch_ready && stall < 300) begin
      @(negedge clk_sys);
      #1;
      stall++;
    end
    if (!ch_ready) chk("send_timeout", 32'(ch_ready), 32'd1);
    @(negedge clk_sys);
    ch_valid = 1'b0;
  endtask

  // Count full-clear writes: expect addr 0..2015 in order, all-ones enables, blank data.
  task automatic count_clear(input string tag, input logic [31:0] exp_din);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    for (int i = 0; i < 2040; i++) begin
      @(negedge clk_sys);
      if (tram_we !== 4'h0) begin
        if (tram_we !== 4'hF) bad++;
        if (32'(tram_addr) !== n) bad++;
        if (tram_din !== exp_din) bad++;
        n++;
      end
    end
    chk({tag, "_writes"}, n, 32'd2016);
    chk({tag, "_bad"}, bad, 32'd0);
  endtask

  // Follow a scroll: count ready-low cycles and the line-blank writes.
  task automatic wait_ready(input int start, input logic [31:0] exp_din,
                            output int low, output int nw, output int bad);
    low = 0;
    nw  = 0;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      if (tram_we !== 4'h0) begin
        if (32'(tram_addr) !== start + nw) bad++;
        if (tram_din !== exp_din) bad++;
        nw++;
      end
      if (ch_ready) break;
      low++;
      @(negedge clk_sys);
    end
  endtask

  initial begin
    int st;
    int tot;
    int low;
    int nw;
    int bad;
    int badsum;

    checks   = 0;
    failures = 0;
    rst_sys  = 1'b1;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    fg_colr  = 4'd15;
    bg_colr  = 4'd0;
    clear    = 1'b0;

    repeat (3) @(negedge clk_sys);
    chk("rst_we", 32'(tram_we), 32'd0);
    chk("rst_addr", 32'(tram_addr), 32'd0);
    chk("rst_din", tram_din, 32'd0);
    chk("rst_scroll", 32'(scroll_offs), 32'd0);
    chk("rst_col", 32'(cur_col), 32'd0);
    chk("rst_row", 32'(cur_row), 32'd0);
    chk("rst_ready", 32'(ch_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    rst_sys = 1'b0;
    #1;
    chk("first_busy", 32'(busy), 32'd1);
    count_clear("init_clear", 32'hF000_0020);
    chk("post_clear_busy", 32'(busy), 32'd0);
    chk("post_clear_ready", 32'(ch_ready), 32'd1);

    // Single character
    fg_colr = 4'd2;
    bg_colr = 4'd1;
    send(8'h41, st);
    chk("a_stall", st, 32'd0);
    chk("a_we", 32'(tram_we), 32'hF);
    chk("a_addr", 32'(tram_addr), 32'd0);
    chk("a_din", tram_din, 32'h2100_0041);
    chk("a_col", 32'(cur_col), 32'd1);

    // CR mid-line
    send(8'h0D, st);
    chk("cr_we", 32'(tram_we), 32'd0);
    chk("cr_col", 32'(cur_col), 32'd0);

    // 85 back-to-back characters: wrap after the 84th
    tot = 0;
    for (int i = 0; i < 85; i++) begin
      send(8'h41, st);
      tot += st;
      if (i == 83) chk("wrap_addr83", 32'(tram_addr), 32'd83);
    end
    chk("wrap_stall", tot, 32'd1);
    chk("wrap_addr84", 32'(tram_addr), 32'd84);
    chk("wrap_row", 32'(cur_row), 32'd1);
    chk("wrap_col", 32'(cur_col), 32'd1);

    // clear and a valid byte together: clear wins
    ch_data  = 8'h42;
    ch_valid = 1'b1;
    clear    = 1'b1;
    #1;
    chk("clr_ready", 32'(ch_ready), 32'd0);
    @(negedge clk_sys);
    ch_valid = 1'b0;
    clear    = 1'b0;
    chk("clr_no_write", 32'(tram_we), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    count_clear("req_clear", 32'h2100_0020);
    chk("req_clear_col", 32'(cur_col), 32'd0);
    chk("req_clear_row", 32'(cur_row), 32'd0);

    // 23 LFs walk down to the last row
    tot = 0;
    for (int i = 0; i < 23; i++) begin
      send(8'h0A, st);
      tot += st;
    end
    @(negedge clk_sys);
    chk("lf_stalls", tot, 32'd22);
    chk("lf_row23", 32'(cur_row), 32'd23);
    chk("lf_scroll0", 32'(scroll_offs), 32'd0);

    // 24th LF scrolls
    send(8'h0A, st);
    wait_ready(0, 32'h2100_0020, low, nw, bad);
    chk("scroll1_low", low, 32'd85);
    chk("scroll1_writes", nw, 32'd84);
    chk("scroll1_bad", bad, 32'd0);
    chk("scroll1_offs", 32'(scroll_offs), 32'd84);
    chk("scroll1_row", 32'(cur_row), 32'd23);

    // Scrolls 2..23
    badsum = 0;
    for (int k = 2; k <= 23; k++) begin
      send(8'h0A, st);
      wait_ready((k - 1) * 84, 32'h2100_0020, low, nw, bad);
      badsum += bad;
      if (low != 85 || nw != 84) badsum++;
    end
    chk("scrolls_bad", badsum, 32'd0);
    chk("scroll23_offs", 32'(scroll_offs), 32'd1932);

    // 24th scroll wraps scroll_offs to 0
    send(8'h0A, st);
    wait_ready(1932, 32'h2100_0020, low, nw, bad);
    chk("scroll24_bad", bad, 32'd0);
    chk("scroll24_writes", nw, 32'd84);
    chk("scroll24_offs", 32'(scroll_offs), 32'd0);

    // BS at column 0
    send(8'h08, st);
    chk("bs0_we", 32'(tram_we), 32'd0);
    chk("bs0_col", 32'(cur_col), 32'd0);

    // Characters land on the bottom line, line_base 1932
    send(8'h58, st);
    chk("x_addr", 32'(tram_addr), 32'd1932);
    chk("x_din", tram_din, 32'h2100_0058);
    send(8'h59, st);
    chk("y_col", 32'(cur_col), 32'd2);
    send(8'h08, st);
    chk("bs_we", 32'(tram_we), 32'd0);
    chk("bs_col", 32'(cur_col), 32'd1);

    // Reset in the middle of a line blank
    send(8'h0A, st);
    repeat (10) @(negedge clk_sys);
    chk("mid_clr_we", 32'(tram_we), 32'hF);
    chk("mid_clr_busy", 32'(busy), 32'd1);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    chk("abort_we", 32'(tram_we), 32'd0);
    chk("abort_addr", 32'(tram_addr), 32'd0);
    chk("abort_din", tram_din, 32'd0);
    chk("abort_scroll", 32'(scroll_offs), 32'd0);
    chk("abort_col", 32'(cur_col), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ch_ready), 32'd0);
    @(negedge clk_sys);
    rst_sys = 1'b0;
    #1;
    chk("restart_busy", 32'(busy), 32'd1);
    count_clear("restart_clear", 32'h2100_0020);
    chk("restart_ready", 32'(ch_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
